// File: rtl/seven_seg_scan_controller.sv
// Eight-digit time-multiplexed scan controller for a common-anode, active-low
// seven-segment display with inter-digit blanking, PWM dimming and double buffering.
module seven_seg_scan_controller #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        RESET,
  input  logic [31:0] DIGITS,
  input  logic [7:0]  EN_MASK,
  input  logic [7:0]  DP_MASK,
  input  logic [3:0]  BRIGHT,
  input  logic        LOAD,
  output logic [7:0]  AN,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic        PENDING,
  output logic        FRAME_DONE
);

  localparam int unsigned SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t        state;
  logic [SW-1:0] slot_cnt;
  logic [2:0]    digit_idx;
  logic [3:0]    pwm_cnt;

  logic [31:0] act_digits, sh_digits;
  logic [7:0]  act_en, sh_en;
  logic [7:0]  act_dp, sh_dp;
  logic [3:0]  act_bright, sh_bright;
  logic        pending;

  logic        slot_wrap;
  logic        frame_end;
  logic        an_on;
  logic [3:0]  cur_nib;
  logic [6:0]  seg_n;
  logic [6:0]  seg_q;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_wrap && (digit_idx == 3'd7);
  assign cur_nib   = act_digits[{digit_idx, 2'b00} +: 4];
  assign an_on     = (state == ST_ON) && act_en[digit_idx] &&
                     ((act_bright == 4'hF) || (pwm_cnt < act_bright));

  // Segment order is {CA,CB,CC,CD,CE,CF,CG}, active-low.
  always_comb begin
    seg_n = 7'h7F;
    case (cur_nib)
      4'h0: seg_n = 7'b0000001;
      4'h1: seg_n = 7'b1001111;
      4'h2: seg_n = 7'b0010010;
      4'h3: seg_n = 7'b0000110;
      4'h4: seg_n = 7'b1001100;
      4'h5: seg_n = 7'b0100100;
      4'h6: seg_n = 7'b0100000;
      4'h7: seg_n = 7'b0001111;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0000100;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b1100000;
      4'hC: seg_n = 7'b0110001;
      4'hD: seg_n = 7'b1000010;
      4'hE: seg_n = 7'b0110000;
      4'hF: seg_n = 7'b0111000;
      default: seg_n = 7'h7F;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      pwm_cnt   <= '0;
      state     <= ST_BLANK;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap)
        digit_idx <= digit_idx + 3'd1;
      if (slot_wrap) begin
        state   <= ST_BLANK;
        pwm_cnt <= pwm_cnt + 4'd1;
      end else if ((state == ST_BLANK) && (slot_cnt == BLANK_LAST)) begin
        state   <= ST_ON;
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + 4'd1;
      end
    end
  end

  // A LOAD coinciding with the frame boundary bypasses the shadow entirely.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      act_digits <= '0;
      act_en     <= '0;
      act_dp     <= '0;
      act_bright <= '0;
      sh_digits  <= '0;
      sh_en      <= '0;
      sh_dp      <= '0;
      sh_bright  <= '0;
      pending    <= 1'b0;
    end else begin
      if (LOAD) begin
        sh_digits <= DIGITS;
        sh_en     <= EN_MASK;
        sh_dp     <= DP_MASK;
        sh_bright <= BRIGHT;
      end
      if (frame_end) begin
        if (LOAD) begin
          act_digits <= DIGITS;
          act_en     <= EN_MASK;
          act_dp     <= DP_MASK;
          act_bright <= BRIGHT;
        end else if (pending) begin
          act_digits <= sh_digits;
          act_en     <= sh_en;
          act_dp     <= sh_dp;
          act_bright <= sh_bright;
        end
        pending <= 1'b0;
      end else if (LOAD) begin
        pending <= 1'b1;
      end
    end
  end

  // Disabled digits also blank their segments and decimal point.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      AN         <= '1;
      seg_q      <= '1;
      DP         <= 1'b1;
      FRAME_DONE <= 1'b0;
    end else begin
      AN         <= an_on ? ~(8'b1 << digit_idx) : '1;
      seg_q      <= act_en[digit_idx] ? seg_n : '1;
      DP         <= ~(act_dp[digit_idx] & act_en[digit_idx]);
      FRAME_DONE <= frame_end;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign PENDING = pending;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Self-checking bench for seven_seg_scan_controller; a frame-position model
// predicts every registered output cycle by cycle.
module tb_seven_seg_scan_controller;

  localparam int DC = 64;
  localparam int BL = 4;
  localparam int FR = 8 * DC;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] DIGITS = '0;
  logic [7:0]  EN_MASK = '0;
  logic [7:0]  DP_MASK = '0;
  logic [3:0]  BRIGHT = '0;
  logic        LOAD = 1'b0;
  logic [7:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG, DP, PENDING, FRAME_DONE;

  seven_seg_scan_controller #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BL)) dut (
    .CLK100MHZ(clk), .RESET(RESET), .DIGITS(DIGITS), .EN_MASK(EN_MASK),
    .DP_MASK(DP_MASK), .BRIGHT(BRIGHT), .LOAD(LOAD), .AN(AN),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
    .DP(DP), .PENDING(PENDING), .FRAME_DONE(FRAME_DONE)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model: frame position plus visible/shadow data sets.
  int          m_p = 0;
  logic [31:0] m_dig = '0, s_dig = '0;
  logic [7:0]  m_en = '0, s_en = '0, m_dp = '0, s_dp = '0;
  logic [3:0]  m_br = '0, s_br = '0;
  logic        m_pend = 1'b0;
  logic [17:0] exp_v;
  logic [17:0] obs;
  logic [6:0]  seg;

  assign seg = {CA, CB, CC, CD, CE, CF, CG};
  assign obs = {AN, seg, DP, PENDING, FRAME_DONE};

  task automatic tick();
    int k, s;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    if (RESET) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      m_p = 0; m_pend = 1'b0;
      m_dig = '0; m_en = '0; m_dp = '0; m_br = '0;
      s_dig = '0; s_en = '0; s_dp = '0; s_br = '0;
    end else begin
      k = m_p / DC;
      s = m_p % DC;
      e_an = 8'hFF;
      if (s >= BL && m_en[k] && (m_br == 4'd15 || ((s - BL) % 16) < int'(m_br)))
        e_an[k] = 1'b0;
      e_seg = m_en[k] ? seg_tab[m_dig[4*k +: 4]] : 7'h7F;
      e_dp  = m_en[k] ? ~m_dp[k] : 1'b1;
      e_fd  = (m_p == FR - 1);
      if (e_fd) begin
        if (LOAD) begin
          m_dig = DIGITS; m_en = EN_MASK; m_dp = DP_MASK; m_br = BRIGHT;
        end else if (m_pend) begin
          m_dig = s_dig; m_en = s_en; m_dp = s_dp; m_br = s_br;
        end
        m_pend = 1'b0;
      end else if (LOAD) begin
        s_dig = DIGITS; s_en = EN_MASK; s_dp = DP_MASK; s_br = BRIGHT;
        m_pend = 1'b1;
      end
      m_p = (m_p + 1) % FR;
    end
    exp_v = {e_an, e_seg, e_dp, m_pend, e_fd};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int fd = 0, fd_at = -1, lit = 0;
    RESET = 1'b1; LOAD = 1'b0;
    repeat (3) begin
      tick();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
    end
    RESET = 1'b0;
    for (int i = 1; i <= FR; i++) begin
      tick();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_idle p=%0d: got %h want %h", m_p, obs, exp_v); end
      if (FRAME_DONE === 1'b1) begin fd++; fd_at = i; end
      if (AN !== 8'hFF || seg !== 7'h7F || DP !== 1'b1 || PENDING !== 1'b0) lit++;
    end
    checks++; if (fd != 1 || fd_at != FR) begin errors++; $display("FAIL reset_frame_done: got %0d pulses at %0d want 1 at %0d", fd, fd_at, FR); end
    checks++; if (lit != 0) begin errors++; $display("FAIL reset_dark: got %0d lit cycles want 0", lit); end
  endtask

  task automatic test_scan_order();
    int low [8];
    int dp_low = 0, guard = 0;
    foreach (low[k]) low[k] = 0;
    DIGITS = 32'h76543210; EN_MASK = 8'hFF; DP_MASK = 8'h01; BRIGHT = 4'd15; LOAD = 1'b1;
    tick(); LOAD = 1'b0;
    checks++; if (PENDING !== 1'b1) begin errors++; $display("FAIL scan_pending: got %b want 1", PENDING); end
    do begin
      tick(); guard++;
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL scan_wait p=%0d: got %h want %h", m_p, obs, exp_v); end
    end while (FRAME_DONE !== 1'b1 && guard < FR + 4);
    checks++; if (guard >= FR + 4) begin errors++; $display("FAIL scan_timeout: got no FRAME_DONE want one within %0d", FR + 4); end
    for (int i = 0; i < FR; i++) begin
      tick();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL scan p=%0d: got %h want %h", i, obs, exp_v); end
      for (int k = 0; k < 8; k++) if (AN === ~(8'b1 << k)) low[k]++;
      if (DP === 1'b0) dp_low++;
      if (i % DC == 32) begin
        checks++; if (seg !== seg_tab[i / DC]) begin errors++; $display("FAIL scan_seg d%0d: got %b want %b", i / DC, seg, seg_tab[i / DC]); end
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++; if (low[k] != DC - BL) begin errors++; $display("FAIL scan_an d%0d: got %0d low want %0d", k, low[k], DC - BL); end
    end
    checks++; if (dp_low != DC) begin errors++; $display("FAIL scan_dp: got %0d low want %0d", dp_low, DC); end
  endtask

  task automatic test_brightness();
    int low;
    for (int pass = 0; pass < 2; pass++) begin
      low = 0;
      EN_MASK = 8'h04; DP_MASK = 8'h00; BRIGHT = (pass == 0) ? 4'd8 : 4'd0; LOAD = 1'b1;
      tick(); LOAD = 1'b0;
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL bright_load: got %h want %h", obs, exp_v); end
      while (m_p != 0) begin
        tick();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL bright_wait p=%0d: got %h want %h", m_p, obs, exp_v); end
      end
      for (int i = 0; i < FR; i++) begin
        tick();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL bright p=%0d: got %h want %h", i, obs, exp_v); end
        if (AN !== 8'hFF) low++;
      end
      checks++; if (low != ((pass == 0) ? 32 : 0)) begin errors++; $display("FAIL bright_count b=%0d: got %0d low want %0d", BRIGHT, low, (pass == 0) ? 32 : 0); end
    end
  endtask

  task automatic test_double_buffer();
    int bad_f = 0, bad_old = 0;
    while (m_p != 100) tick();
    DIGITS = 32'h0; EN_MASK = 8'hFF; BRIGHT = 4'd15; LOAD = 1'b1;
    tick(); LOAD = 1'b0;
    checks++; if (PENDING !== 1'b1) begin errors++; $display("FAIL dbuf_pending: got %b want 1", PENDING); end
    repeat (100) tick();
    DIGITS = 32'hFFFFFFFF; LOAD = 1'b1;
    tick(); LOAD = 1'b0;
    while (m_p != 0) begin
      tick();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL dbuf_hold p=%0d: got %h want %h", m_p, obs, exp_v); end
      if (m_p != 0 && (AN !== 8'hFF && AN !== 8'hFB)) bad_old++;
    end
    checks++; if (bad_old != 0) begin errors++; $display("FAIL dbuf_early: got %0d early-lit cycles want 0", bad_old); end
    checks++; if (PENDING !== 1'b0 || FRAME_DONE !== 1'b1) begin errors++; $display("FAIL dbuf_apply: got pend=%b fd=%b want 0 1", PENDING, FRAME_DONE); end
    for (int i = 0; i < FR; i++) begin
      tick();
      if (i % DC != 0 && seg !== 7'b0111000) bad_f++;
    end
    checks++; if (bad_f != 0) begin errors++; $display("FAIL dbuf_all_f: got %0d non-F cycles want 0", bad_f); end
  endtask

  task automatic test_back_to_back();
    int pend_seen = 0;
    while (m_p != FR - 1) tick();
    DIGITS = 32'h89ABCDE5; EN_MASK = 8'hFF; DP_MASK = 8'h00; BRIGHT = 4'd15; LOAD = 1'b1;
    tick(); LOAD = 1'b0;
    checks++; if (FRAME_DONE !== 1'b1 || PENDING !== 1'b0) begin errors++; $display("FAIL b2b_edge: got fd=%b pend=%b want 1 0", FRAME_DONE, PENDING); end
    for (int i = 0; i < DC; i++) begin
      tick();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b p=%0d: got %h want %h", i, obs, exp_v); end
      if (PENDING !== 1'b0) pend_seen++;
      if (i == 32) begin
        checks++; if (seg !== 7'b0100100) begin errors++; $display("FAIL b2b_digit0: got %b want %b", seg, 7'b0100100); end
      end
    end
    checks++; if (pend_seen != 0) begin errors++; $display("FAIL b2b_pending: got %0d cycles high want 0", pend_seen); end
  endtask

  task automatic test_mask_reset();
    int low [8];
    int fd_at = -1, lit = 0;
    foreach (low[k]) low[k] = 0;
    DIGITS = 32'h76543210; EN_MASK = 8'h0A; BRIGHT = 4'd15; LOAD = 1'b1;
    tick(); LOAD = 1'b0;
    while (m_p != 0) tick();
    for (int i = 0; i < FR; i++) begin
      tick();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL mask p=%0d: got %h want %h", i, obs, exp_v); end
      for (int k = 0; k < 8; k++) if (AN === ~(8'b1 << k)) low[k]++;
      if (FRAME_DONE === 1'b1) fd_at = i;
    end
    for (int k = 0; k < 8; k++) begin
      checks++; if (low[k] != ((k == 1 || k == 3) ? DC - BL : 0)) begin errors++; $display("FAIL mask_an d%0d: got %0d want %0d", k, low[k], (k == 1 || k == 3) ? DC - BL : 0); end
    end
    checks++; if (fd_at != FR - 1) begin errors++; $display("FAIL mask_timing: got frame end at %0d want %0d", fd_at, FR - 1); end
    while (m_p != 5 * DC + 20) tick();
    RESET = 1'b1;
    tick();
    checks++; if (obs !== {8'hFF, 7'h7F, 3'b100}) begin errors++; $display("FAIL mid_reset: got %h want %h", obs, {8'hFF, 7'h7F, 3'b100}); end
    RESET = 1'b0;
    for (int i = 0; i < FR; i++) begin
      tick();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL post_reset p=%0d: got %h want %h", i, obs, exp_v); end
      if (AN !== 8'hFF) lit++;
    end
    checks++; if (lit != 0) begin errors++; $display("FAIL post_reset_dark: got %0d lit want 0", lit); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * FR; i++) begin
      LOAD = ($urandom_range(0, 39) == 0);
      if (LOAD) begin
        DIGITS = $urandom; EN_MASK = 8'($urandom); DP_MASK = 8'($urandom); BRIGHT = 4'($urandom);
      end
      tick();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL random i=%0d: got %h want %h", i, obs, exp_v); end
    end
    LOAD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_brightness();
    test_double_buffer();
    test_back_to_back();
    test_mask_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
